// File: rtl/vga_sync_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_rx_pkg
// Purpose  : Shared constants and state encoding for the VGA sync receiver.
// Revision : 1.0 - initial release
// ============================================================================
package vga_rx_pkg;

  localparam int c_COORD_W = 10;
  localparam logic [c_COORD_W-1:0] c_SAT_VAL = 10'd1023;

  localparam logic [1:0] c_ST_SEARCH  = 2'd0;
  localparam logic [1:0] c_ST_MEASURE = 2'd1;
  localparam logic [1:0] c_ST_CHECK   = 2'd2;
  localparam logic [1:0] c_ST_LOCKED  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/vga_sync_receiver_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Single-bit two-flop synchronizer with selectable reset level.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic board_clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_receiver
// Purpose  : Recovers pixel coordinates and line/frame geometry from VGA syncs
//            and reports lock once the timing repeats stably.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_receiver
  import vga_rx_pkg::*;
#(
  parameter int LOCK_FRAMES   = 2,
  parameter bit HS_ACTIVE_LOW = 1'b1,
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic                 board_clk,
  input  logic                 reset,
  input  logic                 pix_ce,
  input  logic                 vga_h_sync,
  input  logic                 vga_v_sync,
  output logic [c_COORD_W-1:0] rx_x,
  output logic [c_COORD_W-1:0] rx_y,
  output logic [c_COORD_W-1:0] line_len,
  output logic [c_COORD_W-1:0] frame_lines,
  output logic                 locked,
  output logic                 frame_start,
  output logic                 sync_err
);

  localparam logic [2:0] c_LOCK_N = 3'(LOCK_FRAMES);

  logic                 w_hs_raw, w_vs_raw, w_hs, w_vs;
  logic                 r_hs_prev, r_vs_prev;
  logic                 w_hs_edge, w_vs_edge;
  logic [c_COORD_W-1:0] r_x_cnt, r_y_cnt, r_last_h;
  logic [c_COORD_W-1:0] r_line_len, r_frame_lines;
  logic [c_COORD_W-1:0] w_h_meas, w_v_meas, w_h_frame;
  logic                 r_x_sat, r_y_sat, w_x_ovf, w_y_ovf;
  logic [1:0]           r_state, w_state_nxt;
  logic [2:0]           r_match_cnt, w_match_nxt, w_match_inc;
  logic                 w_latch, w_err, w_geom_match, w_h_bad, w_v_bad;
  logic                 r_frame_start, r_sync_err;

  sync_2ff #(.RESET_VAL(HS_ACTIVE_LOW)) u_hs_sync (
    .board_clk (board_clk),
    .reset     (reset),
    .i_async   (vga_h_sync),
    .o_sync    (w_hs_raw)
  );

  sync_2ff #(.RESET_VAL(VS_ACTIVE_LOW)) u_vs_sync (
    .board_clk (board_clk),
    .reset     (reset),
    .i_async   (vga_v_sync),
    .o_sync    (w_vs_raw)
  );

  assign w_hs      = w_hs_raw ^ HS_ACTIVE_LOW;
  assign w_vs      = w_vs_raw ^ VS_ACTIVE_LOW;
  assign w_hs_edge = pix_ce & w_hs & ~r_hs_prev;
  assign w_vs_edge = pix_ce & w_vs & ~r_vs_prev;

  assign w_h_meas  = r_x_cnt + 10'd1;
  assign w_v_meas  = r_y_cnt + 10'd1;
  // A frame's line length is the line closed by the coincident hs edge, if any
  assign w_h_frame = w_hs_edge ? w_h_meas : r_last_h;

  // Saturation flags make an overflow report once per stuck period
  assign w_x_ovf = pix_ce & ~w_hs_edge & (r_x_cnt == c_SAT_VAL) & ~r_x_sat;
  assign w_y_ovf = pix_ce & w_hs_edge & ~w_vs_edge & (r_y_cnt == c_SAT_VAL) & ~r_y_sat;

  assign w_geom_match = (w_h_frame == r_line_len) && (w_v_meas == r_frame_lines);
  assign w_h_bad      = w_hs_edge && (w_h_meas != r_line_len);
  assign w_v_bad      = w_vs_edge && (w_v_meas != r_frame_lines);
  assign w_match_inc  = (r_match_cnt == 3'd7) ? 3'd7 : r_match_cnt + 3'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match_cnt;
    w_latch     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      c_ST_SEARCH: begin
        if (w_vs_edge) w_state_nxt = c_ST_MEASURE;
      end
      c_ST_MEASURE: begin
        if (w_vs_edge) begin
          w_latch     = 1'b1;
          w_match_nxt = 3'd0;
          w_state_nxt = c_ST_CHECK;
        end
      end
      c_ST_CHECK: begin
        if (w_vs_edge) begin
          if (w_geom_match) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc >= c_LOCK_N) w_state_nxt = c_ST_LOCKED;
          end else begin
            w_latch     = 1'b1;
            w_match_nxt = 3'd0;
          end
        end
      end
      c_ST_LOCKED: begin
        if (w_h_bad || w_v_bad) begin
          w_err       = 1'b1;
          w_state_nxt = c_ST_MEASURE;
        end
      end
      default: w_state_nxt = c_ST_SEARCH;
    endcase
    if (w_x_ovf || w_y_ovf) begin
      w_err       = 1'b1;
      w_state_nxt = c_ST_SEARCH;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
      r_x_cnt   <= '0;
      r_y_cnt   <= '0;
      r_last_h  <= '0;
      r_x_sat   <= 1'b0;
      r_y_sat   <= 1'b0;
    end else if (pix_ce) begin
      r_hs_prev <= w_hs;
      r_vs_prev <= w_vs;
      if (w_hs_edge) begin
        r_x_cnt  <= '0;
        r_last_h <= w_h_meas;
        r_x_sat  <= 1'b0;
      end else if (r_x_cnt == c_SAT_VAL) begin
        r_x_sat <= 1'b1;
      end else begin
        r_x_cnt <= r_x_cnt + 10'd1;
      end
      // vs wins over hs for the line counter
      if (w_vs_edge) begin
        r_y_cnt <= '0;
        r_y_sat <= 1'b0;
      end else if (w_hs_edge) begin
        if (r_y_cnt == c_SAT_VAL) r_y_sat <= 1'b1;
        else                      r_y_cnt <= r_y_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_ST_SEARCH;
      r_match_cnt   <= 3'd0;
      r_line_len    <= '0;
      r_frame_lines <= '0;
      r_frame_start <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_match_cnt   <= w_match_nxt;
      r_frame_start <= w_vs_edge;
      r_sync_err    <= w_err;
      if (w_latch) begin
        r_line_len    <= w_h_frame;
        r_frame_lines <= w_v_meas;
      end
    end
  end

  assign rx_x        = r_x_cnt;
  assign rx_y        = r_y_cnt;
  assign line_len    = r_line_len;
  assign frame_lines = r_frame_lines;
  assign locked      = (r_state == c_ST_LOCKED);
  assign frame_start = r_frame_start;
  assign sync_err    = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_receiver
// Purpose  : Randomized-geometry bench for vga_sync_receiver against a
//            frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_receiver;

  localparam int LOCK_N = 2;
  localparam int HS_W   = 4;
  localparam int VS_L   = 2;

  logic       board_clk = 1'b0;
  logic       reset, pix_ce, vga_h_sync, vga_v_sync;
  logic [9:0] rx_x, rx_y, line_len, frame_lines;
  logic       locked, frame_start, sync_err;

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int se_cnt = 0;
  int fs_locked = 0;
  int se_locked = 0;

  // Reference model: geometry is (lines per frame, length of the frame's last line)
  int exp_fs = 0, exp_se = 0;
  bit m_armed = 0, m_locked = 0, err_now = 0;
  int run = 0, ref_ppl = 0, ref_lines = 0;
  int last_lines = 0, last_ppl = 0;

  vga_sync_receiver #(
    .LOCK_FRAMES   (LOCK_N),
    .HS_ACTIVE_LOW (1'b1),
    .VS_ACTIVE_LOW (1'b1)
  ) dut (
    .board_clk   (board_clk),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .vga_h_sync  (vga_h_sync),
    .vga_v_sync  (vga_v_sync),
    .rx_x        (rx_x),
    .rx_y        (rx_y),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .locked      (locked),
    .frame_start (frame_start),
    .sync_err    (sync_err)
  );

  always #5 board_clk = ~board_clk;

  always @(negedge board_clk) begin
    if (frame_start) begin
      fs_cnt++;
      fs_locked = int'(locked);
    end
    if (sync_err) begin
      se_cnt++;
      se_locked = int'(locked);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got checks=%0d required completion", checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Lock needs LOCK_N+1 consecutive identical geometries; any change while locked is an error
  task automatic model_vs(input int g_lines, input int g_ppl);
    exp_fs++;
    if (!m_armed) begin
      m_armed = 1;
      run     = 0;
    end else if (m_locked) begin
      if (g_lines != ref_lines || g_ppl != ref_ppl) begin
        m_locked = 0;
        run      = 0;
        exp_se++;
      end
    end else begin
      if (run > 0 && g_lines == ref_lines && g_ppl == ref_ppl) begin
        run++;
      end else begin
        run       = 1;
        ref_lines = g_lines;
        ref_ppl   = g_ppl;
      end
      if (run >= LOCK_N + 1) m_locked = 1;
    end
  endtask

  task automatic model_line(input int len);
    err_now = 0;
    if (m_locked && len != ref_ppl) begin
      m_locked = 0;
      run      = 0;
      err_now  = 1;
      exp_se++;
    end
  endtask

  task automatic model_clear();
    m_armed  = 0;
    m_locked = 0;
    run      = 0;
  endtask

  task automatic pixel(input bit h, input bit v);
    @(negedge board_clk);
    vga_h_sync = ~h;
    vga_v_sync = ~v;
    pix_ce     = 1'b1;
    @(negedge board_clk);
    pix_ce = 1'b0;
    repeat (2) @(negedge board_clk);
  endtask

  task automatic stall(input bit h, input bit v, input int ex, input int ey);
    for (int k = 0; k < 24; k++) begin
      @(negedge board_clk);
      vga_h_sync = 1'($urandom_range(1, 0));
      vga_v_sync = 1'($urandom_range(1, 0));
    end
    @(negedge board_clk);
    vga_h_sync = ~h;
    vga_v_sync = ~v;
    repeat (3) @(negedge board_clk);
    check_eq("stall_x", int'(rx_x), ex);
    check_eq("stall_y", int'(rx_y), ey);
    check_eq("stall_fs", fs_cnt, exp_fs);
    check_eq("stall_se", se_cnt, exp_se);
  endtask

  task automatic reset_midline();
    @(negedge board_clk);
    reset      = 1'b1;
    vga_h_sync = 1'b1;
    vga_v_sync = 1'b1;
    @(negedge board_clk);
    check_eq("rst_x", int'(rx_x), 0);
    check_eq("rst_y", int'(rx_y), 0);
    check_eq("rst_line_len", int'(line_len), 0);
    check_eq("rst_frame_lines", int'(frame_lines), 0);
    check_eq("rst_locked", int'(locked), 0);
    check_eq("rst_frame_start", int'(frame_start), 0);
    check_eq("rst_sync_err", int'(sync_err), 0);
    @(negedge board_clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic send_frame(input int lines, input int ppl, input int short_l,
                            input int stall_l, input int abort_l);
    int len, prev_len, pick;
    prev_len = ppl;
    for (int l = 0; l < lines; l++) begin
      len  = (l == short_l) ? ppl - 2 : ppl;
      pick = $urandom_range(len - 1, 2);
      for (int i = 0; i < len; i++) begin
        pixel(i < HS_W, l < VS_L);
        if (i == 0 && l > 0) begin
          check_eq("x_wrap", int'(rx_x), prev_len - 1);
          check_eq("y_before_edge", int'(rx_y), l - 1);
        end
        if (i == 1) begin
          if (l == 0) begin
            model_vs(last_lines, last_ppl);
            check_eq("fs_cnt", fs_cnt, exp_fs);
            check_eq("fs_locked", fs_locked, int'(m_locked));
            if (run > 0) begin
              check_eq("line_len", int'(line_len), ref_ppl);
              check_eq("frame_lines", int'(frame_lines), ref_lines);
            end
          end else begin
            model_line(prev_len);
            if (err_now) check_eq("se_locked", se_locked, 0);
          end
          check_eq("se_cnt", se_cnt, exp_se);
          check_eq("locked", int'(locked), int'(m_locked));
        end
        if (i == 1 || i == pick) begin
          check_eq("rx_x", int'(rx_x), i - 1);
          check_eq("rx_y", int'(rx_y), l);
        end
        if (l == stall_l && i == len / 2) stall(1'b0, l < VS_L, i - 1, l);
        if (l == abort_l && i == len / 2) begin
          reset_midline();
          return;
        end
      end
      prev_len = len;
    end
    last_lines = lines;
    last_ppl   = prev_len;
  endtask

  initial begin
    int ppl, lines;
    reset      = 1'b1;
    pix_ce     = 1'b0;
    vga_h_sync = 1'b1;
    vga_v_sync = 1'b1;
    repeat (3) @(negedge board_clk);
    check_eq("init_x", int'(rx_x), 0);
    check_eq("init_y", int'(rx_y), 0);
    check_eq("init_line_len", int'(line_len), 0);
    check_eq("init_frame_lines", int'(frame_lines), 0);
    check_eq("init_locked", int'(locked), 0);
    check_eq("init_frame_start", int'(frame_start), 0);
    check_eq("init_sync_err", int'(sync_err), 0);
    reset = 1'b0;
    model_clear();

    // Nominal acquisition with a pix_ce stall inside one frame
    ppl   = $urandom_range(32, 20);
    lines = $urandom_range(12, 8);
    for (int f = 0; f < 5; f++) send_frame(lines, ppl, -1, (f == 2) ? 3 : -1, -1);
    check_eq("nominal_locked", int'(locked), 1);
    check_eq("nominal_line_len", int'(line_len), ppl);
    check_eq("nominal_frame_lines", int'(frame_lines), lines);

    // One short line while locked, then re-acquire
    send_frame(lines, ppl, $urandom_range(lines - 2, 1), -1, -1);
    for (int f = 0; f < 3; f++) send_frame(lines, ppl, -1, -1, -1);
    check_eq("relock_locked", int'(locked), 1);

    // Reset mid-line while locked, then alternating frame heights never lock
    send_frame(lines, ppl, -1, -1, $urandom_range(lines - 1, 1));
    ppl   = $urandom_range(32, 20);
    lines = $urandom_range(12, 8);
    for (int f = 0; f < 6; f++) send_frame((f % 2 == 0) ? lines : lines - 1, ppl, -1, -1, -1);
    check_eq("alt_locked", int'(locked), 0);

    // Fresh stable geometry locks again
    ppl   = $urandom_range(32, 20);
    lines = $urandom_range(12, 8);
    for (int f = 0; f < 4; f++) send_frame(lines, ppl, -1, -1, -1);
    check_eq("new_geom_locked", int'(locked), 1);

    // hsync missing long enough to saturate the column counter
    for (int p = 0; p < 1100; p++) pixel(1'b0, 1'b0);
    check_eq("ovf_err_seen", (se_cnt > exp_se) ? 1 : 0, 1);
    check_eq("ovf_locked", int'(locked), 0);
    check_eq("ovf_x", int'(rx_x), 1023);
    check_eq("ovf_fs", fs_cnt, exp_fs);
    exp_se = se_cnt;
    model_clear();
    for (int f = 0; f < 5; f++) send_frame(lines, ppl, -1, -1, -1);
    check_eq("post_ovf_locked", int'(locked), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Monitor-side receiver for the board's VGA timing. It takes the `vga_h_sync`/`vga_v_sync` pair produced by the display path and recovers pixel coordinates. It measures line length and frame height, and declares lock once the timing is stable. It sits beside the display path as a self-check and overlay-alignment source, and drives LEDs/SSD with lock status and measured geometry.

## Interface
- `LOCK_FRAMES`, default 2: consecutive matching frames required to assert `locked`.
- `HS_ACTIVE_LOW`, default 1: hsync polarity; 1 means the asserted level is 0.
- `VS_ACTIVE_LOW`, default 1: vsync polarity; 1 means the asserted level is 0.
- `board_clk` in 1: system clock; all logic runs on its rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `pix_ce` in 1: pixel-rate clock enable, one `board_clk` cycle high per pixel (nominally 1 of 4).
- `vga_h_sync` in 1: horizontal sync, asynchronous to `board_clk`.
- `vga_v_sync` in 1: vertical sync, asynchronous to `board_clk`.
- `rx_x` out 10: recovered pixel column; 0 at hsync assertion.
- `rx_y` out 10: recovered line index; 0 at vsync assertion.
- `line_len` out 10: last measured pixels per line.
- `frame_lines` out 10: last measured lines per frame.
- `locked` out 1: timing stable and coordinates valid.
- `frame_start` out 1: one-`board_clk` pulse on each vsync assertion edge.
- `sync_err` out 1: one-`board_clk` pulse on a geometry mismatch or counter overflow.

## Operation
- **Input conditioning**
  - Both sync inputs pass through 2-flop synchronizers on every `board_clk`.
  - They are polarity-normalised to active-high `hs`/`vs`.
  - Previous values are held in registers updated only on `pix_ce`.
  - An edge counts as asserted when `prev=0` and `cur=1`, evaluated only on `pix_ce` cycles.
- **Counters** (all 10-bit, updated only on `pix_ce`)
  - `x_cnt`: increments each `pix_ce`. On an hs assertion edge it loads 0 and its pre-edge value+1 becomes the line measurement.
  - `y_cnt`: increments on each hs assertion edge. On a vs assertion edge it loads 0 and its pre-edge value+1 becomes the frame measurement.
  - If an hs and a vs edge land on the same `pix_ce`, the vs action wins for `y_cnt` and the hs action applies to `x_cnt`.
- **Overflow**: `x_cnt` or `y_cnt` at 1023 and about to increment → `sync_err` pulse, state goes to SEARCH, counters hold at 1023.
- **State machine** (encoding lives in the package):
  - **SEARCH**: `locked=0`; wait for a vs edge, then go to MEASURE.
  - **MEASURE**: capture one full frame. The last hs measurement of the frame latches into `line_len`; the vs measurement latches into `frame_lines`. Clear `match_cnt`, then go to CHECK.
  - **CHECK**: on each vs edge, compare the current frame's measurements against the latched values.
    - Match → `match_cnt+1`; when `match_cnt` reaches `LOCK_FRAMES`, go to LOCKED.
    - Mismatch → relatch the new values, `match_cnt=0`, stay in CHECK, no `sync_err`.
    - `match_cnt` is 3 bits wide and saturates.
  - **LOCKED**: `locked=1`.
    - Any hs measurement ≠ `line_len` → `sync_err`, go to MEASURE.
    - Any vs measurement ≠ `frame_lines` → `sync_err`, go to MEASURE.
    - Both conditions on the same edge produce a single `sync_err` pulse.
- **Outputs**: `rx_x`/`rx_y` always mirror `x_cnt`/`y_cnt`. They are meaningful only while `locked=1`.
- **Reset**: reset mid-frame returns to SEARCH and discards partial measurements.

## Timing
- Reset values: `rx_x=0`, `rx_y=0`, `line_len=0`, `frame_lines=0`, `locked=0`, `frame_start=0`, `sync_err=0`, state=SEARCH, synchronizer and `prev` flops at their de-asserted level.
- Edge latency: an input transition reaches the synchronizer output after 2 `board_clk` cycles, then is detected on the next `pix_ce`. Worst case 2 + 4 `board_clk` cycles.
- Output timing:
  - `frame_start` and `sync_err` are registered and assert the `board_clk` cycle after the detecting `pix_ce`, for exactly 1 cycle.
  - `locked` rises in the same cycle as the final matching `frame_start`.
  - `locked` falls in the same cycle as `sync_err`.
- Minimum lock time after reset: 1 partial frame + 1 measured frame + `LOCK_FRAMES` frames.
- With `pix_ce` stuck low, all state holds and no pulses are produced.

## Structure
- Package `vga_rx_pkg` holds:
  - the state enum (SEARCH, MEASURE, CHECK, LOCKED);
  - the coordinate width constant (10);
  - the saturation constant (1023).
- Sub-module `sync_2ff`: a single-bit 2-flop synchronizer, instantiated twice.
- Counters, compare logic and FSM stay in the top level.

## Test plan
- Nominal 800-pixel × 525-line stimulus, `pix_ce` 1-in-4, `LOCK_FRAMES=2` → `line_len=800`, `frame_lines=525`, `locked` rises at the 4th vs edge after reset. At the hs edge `rx_x` goes 799 → 0.
- After lock, one line shortened to 798 pixels → single `sync_err` pulse, `locked=0`, state returns to MEASURE and re-locks 3 frames later.
- Frame height alternating 525/524 → never locks, `sync_err` stays 0.
- hsync held de-asserted for 1100 pixels → `sync_err` at `x_cnt=1023`, state SEARCH, `locked=0`.
- Reset asserted mid-line while LOCKED → all outputs read 0 in the cycle after reset asserts. After release, lock is re-acquired with the nominal timing.
- hs and vs asserted on the same `pix_ce` → `rx_x=0`, `rx_y=0`, one `frame_start` pulse, no `sync_err`.
